// File: rtl/jtkcpu_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// jtkcpu_muldiv_pkg
// Shared definitions for the jtkcpu multi-cycle multiply/divide unit:
//   - operation mode codes driven on the mode bus
//   - FSM state encoding
//   - small decode helpers and the per-mode iteration count
// No ports (package).
// -----------------------------------------------------------------------------
package jtkcpu_muldiv_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_DIVU = 2'd0;
    localparam mode_t MODE_DIVS = 2'd1;
    localparam mode_t MODE_MULU = 2'd2;
    localparam mode_t MODE_MULS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Bit 1 of the mode selects multiply, bit 0 selects signed operands.
    function automatic logic mode_is_mul(input mode_t m);
        return m[1];
    endfunction

    function automatic logic mode_is_signed(input mode_t m);
        return m[0];
    endfunction

    // Divide walks every dividend bit, multiply walks every multiplier bit.
    function automatic int unsigned iter_count(input mode_t m,
                                               input int unsigned aw,
                                               input int unsigned bw);
        return mode_is_mul(m) ? bw : aw;
    endfunction

endpackage

// File: rtl/jtkcpu_muldiv_if.sv
// -----------------------------------------------------------------------------
// jtkcpu_muldiv_if
// Request/result bundle between the ALU and the multiply/divide unit.
// Parameters: AW (operand A width), BW (operand B width).
// Signals:
//   start  request, sampled when the unit is idle and cen=1
//   mode   operation (MODE_DIVU / MODE_DIVS / MODE_MULU / MODE_MULS)
//   opa    operand A (dividend / multiplicand), AW bits
//   opb    operand B (divisor / multiplier), BW bits
//   busy   operation in progress
//   done   one-cen-cycle pulse, results valid
//   quot   quotient (AW), rem remainder (BW), prod product (AW+BW)
//   v      overflow / divide-by-zero flag
// Modports: master (ALU side), slave (unit side).
// -----------------------------------------------------------------------------
interface jtkcpu_muldiv_if
    import jtkcpu_muldiv_pkg::*;
#(
    parameter int AW = 16,
    parameter int BW = 8
) ();

    logic              start;
    mode_t             mode;
    logic [AW-1:0]     opa;
    logic [BW-1:0]     opb;
    logic              busy;
    logic              done;
    logic [AW-1:0]     quot;
    logic [BW-1:0]     rem;
    logic [AW+BW-1:0]  prod;
    logic              v;

    modport master (
        output start, mode, opa, opb,
        input  busy, done, quot, rem, prod, v
    );

    modport slave (
        input  start, mode, opa, opb,
        output busy, done, quot, rem, prod, v
    );

endinterface

// File: rtl/jtkcpu_muldiv_abs.sv
// -----------------------------------------------------------------------------
// jtkcpu_muldiv_abs
// Conditional two's-complement negate. Used both to take operand magnitudes
// on entry and to restore result signs on exit.
// Parameters: W (data width).
// Ports:
//   neg_i  1  negate when high, pass through when low
//   a_i    W  input value
//   y_o    W  a_i or -a_i (modulo 2^W)
// -----------------------------------------------------------------------------
module jtkcpu_muldiv_abs #(
    parameter int W = 8
) (
    input  logic         neg_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    // The most negative value maps onto itself; read as unsigned it is the
    // correct magnitude, so the core never needs an extra bit.
    assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/jtkcpu_muldiv.sv
// -----------------------------------------------------------------------------
// jtkcpu_muldiv
// Multi-cycle multiply/divide unit for the jtkcpu ALU.
//   - restoring division, one quotient bit per enabled cycle
//   - shift-add multiplication, one multiplier bit per enabled cycle
//   - signed modes work on magnitudes; signs are restored in the FIX state
// FSM: IDLE -> RUN -> FIX -> IDLE (divide by zero goes IDLE -> FIX).
// Latency: done is high N+2 enabled cycles after the start cycle, with
// N = AW for divide and N = BW for multiply; 2 cycles for divide by zero.
//
// Parameters: AW (operand A width, >=4), BW (operand B width, 2..AW).
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset; overrides cen, aborts without done
//   cen  clock enable; every register holds while low
//   bus  jtkcpu_muldiv_if.slave (start/mode/opa/opb in,
//        busy/done/quot/rem/prod/v out)
//
// Build option:
//   JTKCPU_MULDIV_EARLY_EN  multiply leaves RUN as soon as the remaining
//                           multiplier bits are all zero (variable latency,
//                           minimum 2 for opb=0). Divide is unaffected.
// -----------------------------------------------------------------------------
module jtkcpu_muldiv
    import jtkcpu_muldiv_pkg::*;
#(
    parameter int AW = 16,
    parameter int BW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    jtkcpu_muldiv_if.slave bus
);

    localparam int CW = $clog2(AW + 1);
    localparam int PW = AW + BW;

`ifdef JTKCPU_MULDIV_EARLY_EN
    localparam logic EARLY_EN = 1'b1;
`else
    localparam logic EARLY_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    // sh: divide -> dividend shifting out / quotient shifting in (low AW)
    //     multiply -> multiplicand shifting left
    logic [PW-1:0]   sh_q,    sh_d;
    // acc: divide -> partial remainder (low bits); multiply -> product
    logic [PW-1:0]   acc_q,   acc_d;
    // b: divisor (held) or multiplier (shifting right)
    logic [BW-1:0]   b_q,     b_d;
    logic            mul_q,   mul_d;    // operation is a multiply
    logic            sgn_q,   sgn_d;    // operation is signed
    logic            nq_q,    nq_d;     // negate quotient / product
    logic            nr_q,    nr_d;     // negate remainder
    logic            dz_q,    dz_d;     // divide by zero

    logic [AW-1:0]   quot_q,  quot_d;
    logic [BW-1:0]   rem_q,   rem_d;
    logic [PW-1:0]   prod_q,  prod_d;
    logic            v_q,     v_d;
    logic            done_q,  done_d;

    // ------------------------------------------------------------------
    // Operand entry: magnitudes and sign bits
    // ------------------------------------------------------------------
    logic            in_sgn;
    logic            sa, sb;
    logic [AW-1:0]   opa_mag;
    logic [BW-1:0]   opb_mag;
    logic            opb_zero;

    assign in_sgn   = mode_is_signed(bus.mode);
    assign sa       = in_sgn & bus.opa[AW-1];
    assign sb       = in_sgn & bus.opb[BW-1];
    assign opb_zero = (bus.opb == '0);

    jtkcpu_muldiv_abs #(.W(AW)) u_abs_opa (
        .neg_i (sa),
        .a_i   (bus.opa),
        .y_o   (opa_mag)
    );

    jtkcpu_muldiv_abs #(.W(BW)) u_abs_opb (
        .neg_i (sb),
        .a_i   (bus.opb),
        .y_o   (opb_mag)
    );

    // ------------------------------------------------------------------
    // Result sign restoration (consumed in FIX)
    // ------------------------------------------------------------------
    logic [AW-1:0]   quot_fix;
    logic [BW-1:0]   rem_fix;
    logic [PW-1:0]   prod_fix;

    jtkcpu_muldiv_abs #(.W(AW)) u_abs_quot (
        .neg_i (nq_q),
        .a_i   (sh_q[AW-1:0]),
        .y_o   (quot_fix)
    );

    jtkcpu_muldiv_abs #(.W(BW)) u_abs_rem (
        .neg_i (nr_q),
        .a_i   (acc_q[BW-1:0]),
        .y_o   (rem_fix)
    );

    jtkcpu_muldiv_abs #(.W(PW)) u_abs_prod (
        .neg_i (nq_q),
        .a_i   (acc_q),
        .y_o   (prod_fix)
    );

    // ------------------------------------------------------------------
    // Restoring-division step
    // ------------------------------------------------------------------
    logic [BW:0]     div_rs;     // remainder shifted left with next dividend bit
    logic [BW+1:0]   div_trial;  // trial subtraction, MSB is the borrow
    logic            div_ge;     // divisor fits: quotient bit is 1
    logic [BW:0]     div_rem;

    always_comb begin
        div_rs    = {acc_q[BW-1:0], sh_q[AW-1]};
        div_trial = {1'b0, div_rs} - {2'b00, b_q};
        div_ge    = ~div_trial[BW+1];
        div_rem   = div_ge ? div_trial[BW:0] : div_rs;
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        b_d     = b_q;
        mul_d   = mul_q;
        sgn_d   = sgn_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        prod_d  = prod_q;
        v_d     = v_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mul_d = mode_is_mul(bus.mode);
                    sgn_d = in_sgn;
                    nq_d  = sa ^ sb;
                    nr_d  = sa;
                    dz_d  = ~mode_is_mul(bus.mode) & opb_zero;
                    cnt_d = CW'(iter_count(bus.mode, AW, BW));
                    sh_d  = {{BW{1'b0}}, opa_mag};
                    acc_d = '0;
                    b_d   = opb_mag;
                    if (opb_zero && (!mode_is_mul(bus.mode) || EARLY_EN))
                        state_d = ST_FIX;
                    else
                        state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (mul_q) begin
                    acc_d = b_q[0] ? (acc_q + sh_q) : acc_q;
                    sh_d  = sh_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    sh_d  = {{BW{1'b0}}, sh_q[AW-2:0], div_ge};
                    acc_d = {{(AW-1){1'b0}}, div_rem};
                end
                if (cnt_q == CW'(1))
                    state_d = ST_FIX;
                else if (EARLY_EN && mul_q && ((b_q >> 1) == '0))
                    state_d = ST_FIX;
            end

            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (mul_q) begin
                    prod_d = prod_fix;
                    v_d    = 1'b0;
                end else if (dz_q) begin
                    quot_d = '1;
                    rem_d  = '0;
                    v_d    = 1'b1;
                end else begin
                    quot_d = quot_fix;
                    rem_d  = rem_fix;
                    // A negative quotient magnitude never exceeds 2^(AW-1),
                    // so only a positive one with its MSB set overflows.
                    v_d    = sgn_q & ~nq_q & sh_q[AW-1];
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: rst is sampled on the clock edge (synchronous) and takes
    // priority over cen; non-blocking assignments keep every register
    // updating from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            mul_q   <= 1'b0;
            sgn_q   <= 1'b0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            prod_q  <= '0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else if (cen) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            mul_q   <= mul_d;
            sgn_q   <= sgn_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            prod_q  <= prod_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
    assign bus.prod = prod_q;
    assign bus.v    = v_q;

endmodule

// File: doc/jtkcpu_muldiv.md
Name: jtkcpu_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit for the jtkcpu ALU.
- Succeeds the fixed 16/8 unsigned-only divider with a generic-width core.
- Core supports signed/unsigned divide and signed/unsigned multiply through a start/busy/done handshake.
- The ALU instantiates it for DIVXB (div) and LMUL/MUL (mul) and stalls the sequencer while busy.

Parameters:
- AW, 16, width of operand A (dividend / multiplicand), >=4.
- BW, 8, width of operand B (divisor / multiplier), 2..AW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cen  in  1  clock enable; all state advances only when cen=1
- start  in  1  request; sampled only when cen=1 and busy=0
- mode  in  2  operation, see package constants
- opa  in  AW  operand A
- opb  in  BW  operand B
- busy  out  1  operation in progress
- done  out  1  one-cen-cycle pulse, results valid
- quot  out  AW  quotient (div)
- rem  out  BW  remainder (div)
- prod  out  AW+BW  product (mul)
- v  out  1  overflow / divide-by-zero flag

Behaviour:
- Reset: state IDLE. busy, done, v, quot, rem and prod are all 0.
- rst overrides cen and aborts any operation in progress; no done is issued.
- Freeze: with cen=0, state, counter and all outputs hold. done stays high until the next cen=1 edge.
- FSM IDLE -> RUN -> FIX -> IDLE.
  - IDLE, start=1: latch |opa|, |opb| and sign bits (signed modes only), load counter N (AW for div, BW for mul), go RUN. busy=1 from the next cycle.
  - RUN: one restoring-division or shift-add step per cen cycle. Counter decrements; on the step with counter=1, go FIX.
  - FIX: negate quotient if sa^sb, remainder if sa, product if sa^sb. Compute v, register outputs, assert done, drop busy, go IDLE.
- Latency: done is high N+2 cen cycles after the start cycle. For AW=16, BW=8: div 18, mul 10.
- start while busy: ignored, with no side effect.
- start on the same cycle done is high: accepted, since busy=0 then.
- Divide: truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: skip RUN (IDLE -> FIX). quot=all-ones, rem=0, v=1; done 2 cen cycles after start.
- Signed divide overflow: quotient not representable in AW bits signed (e.g. min/-1). Sets v=1; quot holds the low AW bits of the true result.
- Unsigned divide: v=0 except divide by zero.
- Multiply: prod is exact, so v=0 always.
- Multiply output hold: quot/rem hold their previous values after a multiply.
- Divide output hold: prod holds its previous value after a divide.
- All outputs hold until the next done.

Optional Feature:
- Macro: JTKCPU_MULDIV_EARLY_EN.
- Defined, multiply: RUN exits to FIX as soon as the remaining multiplier bits are all zero, so latency is variable (minimum 2 for opb=0).
- Defined, divide: unchanged.
- Undefined: fixed latency as specified.

Decomposition:
- Package jtkcpu_muldiv_pkg holds the mode constants: MODE_DIVU=2'd0, MODE_DIVS=2'd1, MODE_MULU=2'd2, MODE_MULS=2'd3.
- Package also holds the state encoding (IDLE, RUN, FIX) and a function giving the iteration count per mode.
- Sub-module jtkcpu_muldiv_abs (parametrised width): conditional two's-complement negate, shared by operand entry and FIX.

Test Plan:
- DIVU 16'd1000 / 8'd7 -> quot=142, rem=6, v=0; done exactly 18 cen cycles after start; busy high in between.
- DIVS 16'hFC18 (-1000) / 8'd7 -> quot=16'hFF72, rem=8'hFA, v=0. DIVS 16'h8000 / 8'hFF -> v=1.
- DIVU 16'h1234 / 8'h00 -> quot=16'hFFFF, rem=0, v=1; done 2 cen cycles after start.
- MULU 16'h1234 * 8'h56 -> prod=24'h061D78, done after 10 cen cycles. MULS 16'hFFFE * 8'h03 -> prod=24'hFFFFFA.
- cen toggling 1-of-3 during DIVU 1000/7 -> same results; done after 18 enabled cycles. start pulses while busy are ignored.
- rst asserted at RUN step 5 -> next cycle busy=0, done=0, all outputs 0. A fresh start afterwards completes correctly.
